tdp_ram_arbiter: RTL

- Shares one true dual-port block RAM (two read/write ports, 1-cycle registered read) between NUM_REQ requesters in the hybrid tree.
- Grants up to two requests per cycle, in round-robin order, onto RAM ports A and B.
- Serializes same-address hazards between the two ports.
- Routes read data back to the originating requester one cycle after grant.

---
 rtl/tdp_arb_pkg.sv | 25 ++
 rtl/rams_tdp_rf_rf.sv | 50 +++++
 rtl/tdp_ram_arbiter_rr_pick2.sv | 60 ++++++
 rtl/tdp_ram_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/tdp_arb_pkg.sv
// Shared types for the dual-port RAM arbiter: per-port in-flight tag and port indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tdp_arb_pkg;

    // Tag id is sized for the largest supported requester count (8).
    localparam int MAX_REQ  = 8;
    localparam int TAG_ID_W = 3;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    // What a RAM port is doing on behalf of whom, captured at grant time.
    typedef struct packed {
        logic                valid;
        logic                is_read;
        logic [TAG_ID_W-1:0] id;
    } port_tag_t;

    // True when this tag carries a read whose data belongs to requester i.
    function automatic logic tag_hits(input port_tag_t t, input int unsigned i);
        return t.valid && t.is_read && (t.id == TAG_ID_W'(i));
    endfunction

endpackage

// File: rtl/rams_tdp_rf_rf.sv
// True dual-port read-first block RAM, one registered read per port.
// Latency: read data appears on doa/dob one clock after the enabled access.
// Backpressure: none; both ports accept an access every cycle they are enabled.
module rams_tdp_rf_rf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clka,
    input  logic             clkb,
    input  logic             ena,
    input  logic             enb,
    input  logic             wea,
    input  logic             web,
    input  logic [31:0]      addra,
    input  logic [31:0]      addrb,
    input  logic [WIDTH-1:0] dia,
    input  logic [WIDTH-1:0] dib,
    output logic [WIDTH-1:0] doa,
    output logic [WIDTH-1:0] dob
);

    logic [WIDTH-1:0] ram [DEPTH];

    // Only the low address bits select a word; the rest are ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addra[31:AW], addrb[31:AW]};

    // Both write paths live in one process on clka; the arbiter ties clka and
    // clkb together and never lets both ports write the same word in one cycle.
    always_ff @(posedge clka) begin
        if (ena && wea)
            ram[addra[AW-1:0]] <= dia;
        if (enb && web)
            ram[addrb[AW-1:0]] <= dib;
    end

    // Port A read-first output register.
    always_ff @(posedge clka) begin
        if (ena)
            doa <= ram[addra[AW-1:0]];
    end

    // Port B read-first output register.
    always_ff @(posedge clkb) begin
        if (enb)
            dob <= ram[addrb[AW-1:0]];
    end

endmodule

// File: rtl/tdp_ram_arbiter_rr_pick2.sv
// Rotating priority picker: first two valid requesters from ptr, with same-address hazard check.
// Latency: purely combinational.
// Backpressure: second winner is dropped when it collides with the first on an address and either writes.
module rr_pick2 #(
    parameter int  NUM_REQ = 4,
    parameter int  ADDR_W  = 10,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]        valid,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [IDX_W-1:0]          ptr,
    output logic [NUM_REQ-1:0]        gnt_a,
    output logic [NUM_REQ-1:0]        gnt_b,
    output logic                      vld_a,
    output logic                      vld_b,
    output logic [IDX_W-1:0]          idx_a,
    output logic [IDX_W-1:0]          idx_b
);

    logic             cand_vld;
    logic [IDX_W-1:0] cand;
    logic             hazard;

    // Walk requesters from ptr upward; first valid goes to A, second is the B candidate.
    always_comb begin
        int j;
        j        = 0;
        vld_a    = 1'b0;
        idx_a    = '0;
        cand_vld = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (valid[j]) begin
                if (!vld_a) begin
                    vld_a = 1'b1;
                    idx_a = IDX_W'(j);
                end else if (!cand_vld) begin
                    cand_vld = 1'b1;
                    cand     = IDX_W'(j);
                end
            end
        end
    end

    // A same-address pair involving a write is serialized: B idles, A goes first.
    always_comb begin
        hazard = cand_vld
              && (addr[int'(idx_a)*ADDR_W +: ADDR_W] == addr[int'(cand)*ADDR_W +: ADDR_W])
              && (we[idx_a] || we[cand]);
        vld_b  = cand_vld && !hazard;
        idx_b  = cand;
        gnt_a  = '0;
        gnt_b  = '0;
        gnt_a[idx_a] = vld_a;
        gnt_b[idx_b] = vld_b;
    end

endmodule

// File: rtl/tdp_ram_arbiter.sv
// Shares one true dual-port RAM among NUM_REQ requesters, up to two grants per cycle, round-robin.
// Latency: grant is combinational; read data returns on rsp_valid/rsp_data one cycle after grant.
// Backpressure: req_ready low holds a requester; same-address write hazards serialize port B.
module tdp_ram_arbiter
    import tdp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*WIDTH-1:0]  rsp_data,
    output logic                      ram_ena,
    output logic                      ram_wea,
    output logic [31:0]               ram_addra,
    output logic [WIDTH-1:0]          ram_dia,
    input  logic [WIDTH-1:0]          ram_doa,
    output logic                      ram_enb,
    output logic                      ram_web,
    output logic [31:0]               ram_addrb,
    output logic [WIDTH-1:0]          ram_dib,
    input  logic [WIDTH-1:0]          ram_dob
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] gnt_a, gnt_b;
    logic               vld_a, vld_b;
    logic [IDX_W-1:0]   idx_a, idx_b;
    logic               go_a, go_b;
    logic [IDX_W-1:0]   last_idx;
    port_tag_t          tag_q [2];
    logic [NUM_REQ*WIDTH-1:0] hold_q;

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W)
    ) u_pick (
        .valid (req_valid),
        .we    (req_we),
        .addr  (req_addr),
        .ptr   (rr_ptr),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .vld_a (vld_a),
        .vld_b (vld_b),
        .idx_a (idx_a),
        .idx_b (idx_b)
    );

    // Nothing is granted while reset is held, even though reset is asynchronous.
    always_comb begin
        go_a      = vld_a && !rst;
        go_b      = vld_b && !rst;
        req_ready = rst ? '0 : (gnt_a | gnt_b);
        last_idx  = go_b ? idx_b : idx_a;
    end

    // Drive each RAM port from its winner, or park it fully at zero when idle.
    always_comb begin
        ram_ena   = go_a;
        ram_wea   = go_a && req_we[idx_a];
        ram_addra = go_a ? 32'(req_addr[int'(idx_a)*ADDR_W +: ADDR_W]) : '0;
        ram_dia   = go_a ? req_wdata[int'(idx_a)*WIDTH +: WIDTH] : '0;
        ram_enb   = go_b;
        ram_web   = go_b && req_we[idx_b];
        ram_addrb = go_b ? 32'(req_addr[int'(idx_b)*ADDR_W +: ADDR_W]) : '0;
        ram_dib   = go_b ? req_wdata[int'(idx_b)*WIDTH +: WIDTH] : '0;
    end

    // Round-robin pointer moves past the last requester granted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (go_a)
            rr_ptr <= (last_idx == IDX_W'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
    end

    // Remember who each port is serving so its read data can be steered back next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q[PORT_A] <= '0;
            tag_q[PORT_B] <= '0;
        end else begin
            tag_q[PORT_A] <= port_tag_t'{valid: go_a, is_read: go_a && !req_we[idx_a], id: TAG_ID_W'(idx_a)};
            tag_q[PORT_B] <= port_tag_t'{valid: go_b, is_read: go_b && !req_we[idx_b], id: TAG_ID_W'(idx_b)};
        end
    end

    // Steer port data to the tagged requester; others keep their last returned word.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = hold_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_hits(tag_q[PORT_A], i)) begin
                rsp_valid[i]               = 1'b1;
                rsp_data[i*WIDTH +: WIDTH] = ram_doa;
            end else if (tag_hits(tag_q[PORT_B], i)) begin
                rsp_valid[i]               = 1'b1;
                rsp_data[i*WIDTH +: WIDTH] = ram_dob;
            end
        end
    end

    // Capture the presented response words so they hold while not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_q <= '0;
        else
            hold_q <= rsp_data;
    end

endmodule
